aes_cipher_stream_ctrl: RTL and testbench

//  Queued, single-clock front end for aes_cipher_top. Accepts encryption requests over a valid/ready

---
 rtl/aes_cipher_stream_ctrl_pkg.sv | 24 ++
 rtl/aes_cipher_stream_ctrl_if.sv | 34 +++
 rtl/aes_cipher_stream_ctrl_req_fifo.sv | 66 ++++++
 rtl/aes_cipher_top.sv | 135 +++++++++++++
 rtl/aes_cipher_stream_ctrl.sv | 127 ++++++++++++
 tb/tb_aes_cipher_stream_ctrl.sv | 264 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_cipher_stream_ctrl_pkg.sv
// Shared types for the AES stream controller.
// Provides FSM/mode encodings, block width and the mask helper.
package aes_cipher_stream_ctrl_pkg;

  localparam int AES_BLK_W = 128;

  localparam logic AES_MODE_PLAIN = 1'b0;
  localparam logic AES_MODE_MASK  = 1'b1;

  typedef logic [AES_BLK_W-1:0] blk_t;

  typedef enum logic {
    AES_SC_IDLE = 1'b0,
    AES_SC_RUN  = 1'b1
  } aes_sc_state_e;

  function automatic blk_t mask_sel(
    input logic mode,
    input blk_t mask
  );
    return (mode == AES_MODE_MASK) ? mask : '0;
  endfunction

endpackage

// File: rtl/aes_cipher_stream_ctrl_if.sv
// Request/response handshake bundle for the AES stream controller.
// master = request producer / result consumer, slave = the controller.
interface aes_cipher_stream_ctrl_if
  import aes_cipher_stream_ctrl_pkg::*;
#(
  parameter int TAG_W = 4
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_mode;
  logic [TAG_W-1:0] req_tag;
  blk_t             req_text;
  blk_t             req_mask;
  logic             rsp_valid;
  logic             rsp_ready;
  blk_t             rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_mode, req_tag,
    output req_text, req_mask, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_mode, req_tag,
    input  req_text, req_mask, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_data, rsp_tag
  );

endinterface

// File: rtl/aes_cipher_stream_ctrl_req_fifo.sv
// Register-based request FIFO, head word visible combinationally.
// Ports: push/din, pop/dout, full, empty, level (0..DEPTH).
module aes_req_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/aes_cipher_top.sv
// Iterative AES-128 encrypt core, one round per cycle.
// Ports: rst (active-low), ld, key, text_in -> done pulse, text_out.
module aes_cipher_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  output logic         done,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic [127:0] text_out
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
         ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3r, tmp, n0, n1, n2, n3;
    w3r = {k[23:0], k[31:24]};
    tmp = {sbox(w3r[31:24]) ^ rc, sbox(w3r[23:16]),
           sbox(w3r[15:8]), sbox(w3r[7:0])};
    n0 = k[127:96] ^ tmp;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Byte i sits at row i%4, column i/4; ShiftRows folds into the S-box gather.
  function automatic logic [127:0] aes_round(
    input logic [127:0] s,
    input logic [127:0] k,
    input logic         last
  );
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else o[127-32*c -: 32] = {
        xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
        xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o ^ k;
  endfunction

  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d, nk;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         run_q, run_d;
  logic         done_q, done_d;

  assign nk       = key_next(rk_q, rcon_q);
  assign done     = done_q;
  assign text_out = state_q;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    if (ld) begin
      state_d = text_in ^ key;
      rk_d    = key;
      rcon_d  = 8'h01;
      cnt_d   = 4'd1;
      run_d   = 1'b1;
    end else if (run_q) begin
      state_d = aes_round(state_q, nk, cnt_q == 4'd10);
      rk_d    = nk;
      rcon_d  = xt(rcon_q);
      cnt_d   = cnt_q + 4'd1;
      if (cnt_q == 4'd10) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= '0;
      rk_q    <= '0;
      rcon_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      rcon_q  <= rcon_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/aes_cipher_stream_ctrl.sv
// Queued front end for aes_cipher_top: FIFO, issue FSM, tagged results.
// Ports: clk, rst, key, bus (slave handshake), level, busy.
module aes_cipher_stream_ctrl
  import aes_cipher_stream_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  blk_t                   key,
  aes_cipher_stream_ctrl_if.slave bus,
  output logic [AW:0]            level,
  output logic                   busy
);

  localparam int EW = 1 + TAG_W + 2 * AES_BLK_W;

  logic             f_full, f_empty, push, issue;
  logic [EW-1:0]    f_din, f_dout;
  logic             h_mode;
  logic [TAG_W-1:0] h_tag;
  blk_t             h_text, h_mask;
  logic             core_ld, core_done;
  blk_t             core_out;

  aes_sc_state_e    state_q, state_d;
  logic             mode_q, mode_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  blk_t             mask_q, mask_d;
  logic             rsp_valid_q, rsp_valid_d;
  blk_t             rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  assign f_din = {bus.req_mode, bus.req_tag, bus.req_text, bus.req_mask};
  assign {h_mode, h_tag, h_text, h_mask} = f_dout;
  assign push = bus.req_valid & ~f_full;

  // Issue only from registered state, and only when the output slot frees.
  assign issue = (state_q == AES_SC_IDLE) & ~f_empty
               & (~rsp_valid_q | bus.rsp_ready);
  assign core_ld = issue;

  aes_req_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (f_din),
    .pop   (issue),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .level (level)
  );

  aes_cipher_top u_core (
    .clk      (clk),
    .rst      (~rst),
    .ld       (core_ld),
    .done     (core_done),
    .key      (key),
    .text_in  (h_text),
    .text_out (core_out)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    tag_d       = tag_q;
    mask_d      = mask_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
    unique case (1'b1)
      (state_q == AES_SC_IDLE): begin
        if (issue) begin
          mode_d  = h_mode;
          tag_d   = h_tag;
          mask_d  = h_mask;
          state_d = AES_SC_RUN;
        end
      end
      (state_q == AES_SC_RUN): begin
        if (core_done) begin
          rsp_data_d  = core_out ^ mask_sel(mode_q, mask_q);
          rsp_tag_d   = tag_q;
          rsp_valid_d = 1'b1;
          state_d     = AES_SC_IDLE;
        end
      end
      default: state_d = AES_SC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= AES_SC_IDLE;
      mode_q      <= AES_MODE_PLAIN;
      tag_q       <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      tag_q       <= tag_d;
      mask_q      <= mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign bus.req_ready = ~f_full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign busy = ~f_empty | (state_q == AES_SC_RUN) | rsp_valid_q;

endmodule

// File: tb/tb_aes_cipher_stream_ctrl.sv
// Scoreboard bench for aes_cipher_stream_ctrl.
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_aes_cipher_stream_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int TAG_W = 4;
  localparam int LC    = 11;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CTN = 128'h963b1f279584fbcf2732487f8f4b3aa5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [127:0]  key;
  logic [AW:0]   level;
  logic          busy;

  aes_cipher_stream_ctrl_if #(.TAG_W(TAG_W)) bus ();

  aes_cipher_stream_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .TAG_W (TAG_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .key   (key),
    .bus   (bus),
    .level (level),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [127:0]     data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic mode, input logic [TAG_W-1:0] tag,
                      input logic [127:0] mask, input logic [127:0] exp);
    int   n;
    logic ok;
    exp_t e;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_mode  = mode;
    bus.req_tag   = tag;
    bus.req_text  = PT;
    bus.req_mask  = mask;
    do begin
      @(negedge clk);
      ok = bus.req_ready;
      step();
      n++;
    end while (!ok && n < 100);
    chk("push_accept", 128'(ok), 128'd1);
    if (ok) begin
      e.tag  = tag;
      e.data = exp;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 60);
    chk(nm, 128'(bus.rsp_valid), 128'd1);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 400) begin
      step();
      n++;
    end
    chk(nm, 128'(n < 400), 128'd1);
  endtask

  logic             held = 1'b0;
  logic [127:0]     held_data;
  logic [TAG_W-1:0] held_tag;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("rsp_hold_valid", 128'(bus.rsp_valid), 128'd1);
        chk("rsp_hold_data", bus.rsp_data, held_data);
        chk("rsp_hold_tag", 128'(bus.rsp_tag), 128'(held_tag));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected tag=%h data=%h required=none",
                   bus.rsp_tag, bus.rsp_data);
        end else begin
          e = sb.pop_front();
          chk("rsp_tag", 128'(bus.rsp_tag), 128'(e.tag));
          chk("rsp_data", bus.rsp_data, e.data);
        end
      end
      held      = bus.rsp_valid && !bus.rsp_ready;
      held_data = bus.rsp_data;
      held_tag  = bus.rsp_tag;
    end
  end

  initial begin
    int   n;
    int   cnt;
    exp_t e;
    logic [127:0] m;
    key           = KEY;
    bus.req_valid = 1'b0;
    bus.req_mode  = 1'b0;
    bus.req_tag   = '0;
    bus.req_text  = '0;
    bus.req_mask  = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 128'(bus.req_ready), 128'd1);
    chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    chk("rst_rsp_data", bus.rsp_data, 128'd0);
    chk("rst_rsp_tag", 128'(bus.rsp_tag), 128'd0);
    chk("rst_level", 128'(level), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    step();

    // FIPS-197 plain, latency from accept
    bus.rsp_ready = 1'b1;
    push(1'b0, 4'd3, '0, CT);
    idle();
    wait_rsp("t1_rsp_seen", n);
    chk("t1_latency", 128'(n), 128'(LC + 2));
    drain("t1_drain");

    // masked with all-ones
    push(1'b1, 4'd5, {128{1'b1}}, CTN);
    idle();
    drain("t2_drain");

    // back-to-back overfill
    for (int i = 0; i <= DEPTH; i++) begin
      m = {16{8'(i * 17 + 1)}};
      push(1'b1, TAG_W'(i), m, CT ^ m);
    end
    idle();
    @(negedge clk);
    chk("t3_req_ready_full", 128'(bus.req_ready), 128'd0);
    chk("t3_level_full", 128'(level), 128'(DEPTH));
    step();
    drain("t3_drain");

    // back-pressure on result
    bus.rsp_ready = 1'b0;
    push(1'b1, 4'd6, 128'h0f0f, CT ^ 128'h0f0f);
    push(1'b0, 4'd7, 128'hdead, CT);
    idle();
    wait_rsp("t4_rsp_seen", n);
    repeat (5) step();
    @(negedge clk);
    chk("t4_valid_held", 128'(bus.rsp_valid), 128'd1);
    chk("t4_tag_held", 128'(bus.rsp_tag), 128'd6);
    chk("t4_data_held", bus.rsp_data, CT ^ 128'h0f0f);
    chk("t4_level", 128'(level), 128'd1);
    chk("t4_busy", 128'(busy), 128'd1);
    step();
    bus.rsp_ready = 1'b1;
    drain("t4_drain");

    // reset while running with two queued
    push(1'b0, 4'd8, '0, CT);
    push(1'b0, 4'd9, '0, CT);
    push(1'b0, 4'd10, '0, CT);
    idle();
    repeat (4) step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    chk("t5_level", 128'(level), 128'd0);
    chk("t5_req_ready", 128'(bus.req_ready), 128'd1);
    chk("t5_busy", 128'(busy), 128'd0);
    cnt = 0;
    repeat (3 * LC) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt++;
    end
    chk("t5_no_stale_rsp", 128'(cnt), 128'd0);
    step();

    // push into empty FIFO in the cycle the result pops
    bus.rsp_ready = 1'b0;
    push(1'b0, 4'd11, '0, CT);
    idle();
    wait_rsp("t6_first_seen", n);
    step();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_mode  = 1'b1;
    bus.req_tag   = 4'd12;
    bus.req_text  = PT;
    bus.req_mask  = 128'h5555;
    @(negedge clk);
    chk("t6_accept_ready", 128'(bus.req_ready), 128'd1);
    chk("t6_ld_same_cycle", 128'(dut.core_ld), 128'd0);
    step();
    e.tag  = 4'd12;
    e.data = CT ^ 128'h5555;
    sb.push_back(e);
    idle();
    @(negedge clk);
    chk("t6_ld_next_cycle", 128'(dut.core_ld), 128'd1);
    n = 1;
    while (!bus.rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t6_latency", 128'(n), 128'(LC + 2));
    drain("t6_drain");

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
